// File: rtl/clock_run_ctrl_pkg.sv
// clock_run_ctrl_pkg: shared state encoding, default divisors and widths
// for the CPU clock-run controller and its button debouncers.
package clock_run_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        STEP_WAIT = 2'b01,
        HALTED    = 2'b10
    } run_state_t;

    localparam int DEF_FAST_DIV        = 10;
    localparam int DEF_SLOW_DIV        = 1000000;
    localparam int DEF_DEBOUNCE_CYCLES = 100000;

    // Wide enough for the slow divisor with plenty of headroom.
    localparam int PRESC_W = 32;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stable-level counter for a raw button.
// Ports: clk, rst (async, active high), btn (raw) -> level (debounced).
module btn_debounce
    import clock_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // level follows sync2 only after it has disagreed for DEBOUNCE_CYCLES
    // consecutive cycles; any agreeing cycle restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_run_ctrl.sv
// clock_run_ctrl: CPU clock-enable generator with free-run, single-step and halt.
// Ports: rawClk, rst, frequency, step_mode, step_btn, resume_btn, halt
//        -> cpu_en (1-cycle pulse), halted, cycle_count[31:0].
// Optional feature: define CLOCK_RUN_CYCLE_COUNTER_EN to build the pulse counter.
module clock_run_ctrl
    import clock_run_ctrl_pkg::*;
#(
    parameter int FAST_DIV        = DEF_FAST_DIV,
    parameter int SLOW_DIV        = DEF_SLOW_DIV,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic        rawClk,
    input  logic        rst,
    input  logic        frequency,
    input  logic        step_mode,
    input  logic        step_btn,
    input  logic        resume_btn,
    input  logic        halt,
    output logic        cpu_en,
    output logic        halted,
    output logic [31:0] cycle_count
);

    run_state_t         state;
    run_state_t         next_state;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] div_m1;
    logic               freq_q;
    logic               freq_vld;
    logic               freq_chg;
    logic               step_lvl;
    logic               step_prev;
    logic               step_rise;
    logic               step_pend;
    logic               resume_lvl;
    logic               resume_prev;
    logic               resume_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk   (rawClk),
        .rst   (rst),
        .btn   (step_btn),
        .level (step_lvl)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_resume_db (
        .clk   (rawClk),
        .rst   (rst),
        .btn   (resume_btn),
        .level (resume_lvl)
    );

    assign step_rise   = step_lvl & ~step_prev;
    assign resume_rise = resume_lvl & ~resume_prev;
    assign div_m1      = frequency ? PRESC_W'(FAST_DIV - 1)
                                   : PRESC_W'(SLOW_DIV - 1);
    // freq_vld masks the first cycle after reset, when freq_q is not yet
    // a real history of the input.
    assign freq_chg    = freq_vld & (frequency ^ freq_q);

    always_ff @(posedge rawClk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            RUN: begin
                if (halt) begin
                    next_state = HALTED;
                end else if (step_mode) begin
                    next_state = STEP_WAIT;
                end
            end
            STEP_WAIT: begin
                if (halt) begin
                    next_state = HALTED;
                end else if (!step_mode) begin
                    next_state = RUN;
                end
            end
            HALTED: begin
                if (resume_rise) begin
                    next_state = step_mode ? STEP_WAIT : RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        cpu_en = 1'b0;
        halted = 1'b0;
        unique case (state)
            RUN:       cpu_en = ~halt & ~freq_chg & (presc == div_m1);
            STEP_WAIT: cpu_en = ~halt & step_pend;
            HALTED:    halted = 1'b1;
            default:   ;
        endcase
    end

    // Prescaler only advances while staying in RUN; any mode change,
    // frequency change or wrap sends it back to 0.
    always_ff @(posedge rawClk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (state != RUN || next_state != RUN ||
                     freq_chg || presc == div_m1) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge rawClk or posedge rst) begin
        if (rst) begin
            freq_q      <= 1'b0;
            freq_vld    <= 1'b0;
            step_prev   <= 1'b0;
            resume_prev <= 1'b0;
            step_pend   <= 1'b0;
        end else begin
            freq_q      <= frequency;
            freq_vld    <= 1'b1;
            step_prev   <= step_lvl;
            resume_prev <= resume_lvl;
            step_pend   <= (state == STEP_WAIT) & step_rise;
        end
    end

`ifdef CLOCK_RUN_CYCLE_COUNTER_EN
    always_ff @(posedge rawClk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (cpu_en) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule
